// File: rtl/sync_fifo_buffer.sv
// Single-clock circular FIFO with full/empty flags.
// Read port is either first-word-fall-through or a registered standard read.
module sync_fifo_buffer #(
   parameter int unsigned FIFO_DEPTH = 32,
   parameter int unsigned FWFT       = 1,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  write_i,
   input  logic                  read_i,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic                  full_o,
   output logic                  empty_o
);

   localparam int unsigned AW         = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [AW:0]           count;
   logic                  wr_en;
   logic                  rd_en;

   assign empty_o = (count == '0);
   assign full_o  = (count == FULL_COUNT);

   // A read frees a slot in the same edge, so a full FIFO still accepts write+read.
   assign rd_en = read_i & ~empty_o;
   assign wr_en = write_i & (~full_o | read_i);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         unique case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && wr_en) begin
         mem[wr_ptr] <= wr_data_i;
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign rd_data_o = mem[rd_ptr];
      end else begin : g_std
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               rd_data_o <= '0;
            end else if (rd_en) begin
               rd_data_o <= mem[rd_ptr];
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_sync_fifo_buffer.sv
// Scoreboard bench: one FWFT and one standard-read FIFO driven with identical stimulus,
// checked against a queue-based reference model.
module tb_sync_fifo_buffer;

   localparam int unsigned D = 32;

   logic       clk = 1'b0;
   logic       rst_i = 1'b0;
   logic [7:0] wr_data_i = '0;
   logic       write_i = 1'b0;
   logic       read_i = 1'b0;
   logic [7:0] rd_f, rd_s;
   logic       full_f, empty_f, full_s, empty_s;

   int errors = 0;
   int checks = 0;

   logic [7:0] mdl[$];
   logic [7:0] exp_f[$];
   logic [7:0] exp_s[$];
   bit         model_valid = 0;

   sync_fifo_buffer #(.FIFO_DEPTH(D), .FWFT(1), .DATA_WIDTH(8)) dut_fwft (
      .clk_i(clk), .rst_i(rst_i), .wr_data_i(wr_data_i), .write_i(write_i),
      .read_i(read_i), .rd_data_o(rd_f), .full_o(full_f), .empty_o(empty_f));

   sync_fifo_buffer #(.FIFO_DEPTH(D), .FWFT(0), .DATA_WIDTH(8)) dut_std (
      .clk_i(clk), .rst_i(rst_i), .wr_data_i(wr_data_i), .write_i(write_i),
      .read_i(read_i), .rd_data_o(rd_s), .full_o(full_s), .empty_o(empty_s));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
      end
   endtask

   // Checks flags from the last edge, drives one cycle of inputs, advances the model.
   task automatic step(input logic r, input logic w, input logic rd, input logic [7:0] d);
      int unsigned sz;
      logic [7:0]  v;
      if (model_valid) begin
         chk("empty_fwft", empty_f, mdl.size() == 0);
         chk("full_fwft",  full_f,  mdl.size() == D);
         chk("empty_std",  empty_s, mdl.size() == 0);
         chk("full_std",   full_s,  mdl.size() == D);
      end
      rst_i     = r;
      write_i   = w;
      read_i    = rd;
      wr_data_i = d;
      if (r) begin
         mdl.delete();
         model_valid = 1;
      end else begin
         sz = mdl.size();
         if (rd && sz > 0) begin
            v = mdl.pop_front();
            exp_f.push_back(v);
            exp_s.push_back(v);
         end
         if (w && (sz < D || rd)) mdl.push_back(d);
      end
      @(posedge clk);
      #1;
   endtask

   // FWFT monitor: the displayed word is the one popped at the coming edge.
   always @(negedge clk) begin
      if (!rst_i && read_i && !empty_f) begin
         if (exp_f.size() == 0) chk("fwft_unexpected_pop", 1, 0);
         else chk("fwft_data", rd_f, exp_f.pop_front());
      end
   end

   // Standard-mode monitor: data appears one edge after the read, then holds.
   bit         s_pend = 0;
   bit         s_rst_pend = 0;
   bit         s_started = 0;
   logic [7:0] s_hold = '0;
   always @(negedge clk) begin
      if (s_rst_pend) begin
         s_hold    = '0;
         s_started = 1;
      end
      if (s_pend) begin
         if (exp_s.size() == 0) chk("std_unexpected_pop", 1, 0);
         else begin
            s_hold = exp_s.pop_front();
            chk("std_data", rd_s, s_hold);
         end
      end else if (s_started) begin
         chk("std_hold", rd_s, s_hold);
      end
      s_rst_pend = rst_i;
      s_pend     = !rst_i && read_i && !empty_s;
   end

   initial begin
      // reset with a write pending
      step(1, 1, 0, 8'h77);
      step(1, 1, 0, 8'h78);
      step(0, 0, 0, 8'h00);
      // ordering
      step(0, 1, 0, 8'hA1);
      step(0, 1, 0, 8'hB2);
      step(0, 1, 0, 8'hC3);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 8'h00);
      step(0, 0, 0, 8'h00);
      // fill, overflow attempt, write+read while full, drain
      for (int i = 0; i < int'(D); i++) step(0, 1, 0, 8'(i));
      step(0, 1, 0, 8'hFF);
      step(0, 1, 1, 8'h55);
      for (int i = 0; i < int'(D); i++) step(0, 0, 1, 8'h00);
      // empty corners
      step(0, 0, 1, 8'h00);
      step(0, 0, 1, 8'h00);
      step(0, 1, 1, 8'h3C);
      step(0, 0, 0, 8'h00);
      step(0, 0, 1, 8'h00);
      step(0, 0, 0, 8'h00);
      // steady streaming across several wraps
      for (int i = 0; i < 16; i++) step(0, 1, 0, 8'($urandom));
      for (int i = 0; i < 3 * int'(D); i++) step(0, 1, 1, 8'($urandom));
      for (int i = 0; i < 20; i++) step(0, 0, 1, 8'h00);
      // random traffic
      for (int i = 0; i < 400; i++)
         step(0, $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50, 8'($urandom));
      // mid-stream reset, then random again
      step(1, 1, 1, 8'hEE);
      step(0, 0, 0, 8'h00);
      for (int i = 0; i < 200; i++)
         step(0, $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 30, 8'($urandom));
      for (int i = 0; i < int'(D) + 4; i++) step(0, 0, 1, 8'h00);
      step(0, 0, 0, 8'h00);
      step(0, 0, 0, 8'h00);
      @(negedge clk);
      chk("fwft_queue_drained", exp_f.size(), 0);
      chk("std_queue_drained", exp_s.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
